riscv_lsu: RTL and testbench
============================

RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 SHALL have parameter AW, default 32, meaning address width (min 8).
REQ-002 SHALL have parameter RAM_REGION, default 4'h8, meaning required value of addr[AW-1:AW-4] for a legal access.
REQ-003 SHALL have parameter TIMEOUT, default 16, meaning max BUS-state cycles before fault; 0 disables the timeout.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  core access request.
REQ-007 SHALL have port req_ready  output  1  LSU can accept request.
REQ-008 SHALL have port req_store  input  1  1=store, 0=load.
REQ-009 SHALL have port req_funct3  input  3  RV32I load/store funct3.
REQ-010 SHALL have port req_addr  input  AW  byte address.
REQ-011 SHALL have port req_wdata  input  32  store data (rs2).
REQ-012 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have port resp_err  output  1  access fault, qualified by resp_valid.
REQ-014 SHALL have port resp_rdata  output  32  extended load data, qualified by resp_valid.
REQ-015 SHALL have ports mem_valid out 1, mem_ready in 1, mem_addr out AW (word-aligned), mem_we out 4, mem_wdata out 32, mem_rdata in 32 (valid when mem_valid&mem_ready).

Function
REQ-016 SHALL implement FSM states IDLE, BUS, RESP; req_ready=1 only in IDLE.
REQ-017 SHALL accept a request on req_valid&req_ready and register funct3, store, addr, wdata.
REQ-018 SHALL flag fault at accept on: region mismatch; funct3 in {3,6,7} or store funct3>2; halfword with addr[0]=1; word with addr[1:0]!=0.
REQ-019 SHALL on fault go IDLE->RESP (resp_valid, resp_err=1 next cycle), never asserting mem_valid.
REQ-020 SHALL otherwise go IDLE->BUS, holding mem_valid=1 and all mem_* stable until mem_ready.
REQ-021 SHALL in BUS on mem_ready capture mem_rdata and go to RESP; zero-wait latency is accept->resp_valid 2 cycles.
REQ-022 SHALL in BUS count cycles; when TIMEOUT!=0 and count reaches TIMEOUT without mem_ready, drop mem_valid and go to RESP with resp_err=1.
REQ-023 SHALL in RESP assert resp_valid for exactly one cycle, then return to IDLE.
REQ-024 SHALL drive mem_addr={addr[AW-1:2],2'b00}.
REQ-025 SHALL drive mem_we: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111; loads 4'b0000.
REQ-026 SHALL replicate store data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
REQ-027 SHALL select load byte/half by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-028 SHALL drive resp_rdata=0 on stores and faults.
REQ-029 SHALL ignore req_valid outside IDLE; no queuing.
REQ-030 SHALL treat mem_ready outside BUS as don't-care.

Reset
REQ-031 SHALL on reset (any state, incl. mid-BUS) enter IDLE next edge, clearing mem_valid, resp_valid, resp_err, mem_we, timeout counter, resp_rdata to 0, with req_ready=1.
REQ-032 SHALL let reset take priority over mem_ready and req_valid in the same cycle.

Structure
REQ-033 SHALL place state enum, funct3 constants (LB..LHU, SB..SW) and fault-check function in shared package riscv_lsu_pkg.
REQ-034 SHALL use one combinational sub-module lsu_align (mask, store replication, load extraction/extension).
REQ-035 SHALL size the timeout counter $clog2(TIMEOUT+1), min 1 bit.

Verification
REQ-036 SHALL cover SB addr 0x8000_0003 wdata 0x0000_00A5, mem_ready same cycle -> mem_we=4'b1000, mem_wdata=0xA5A5_A5A5, resp_valid 2 cycles after accept, resp_err=0.
REQ-037 SHALL cover LH addr 0x8000_0002, mem_rdata 0x8001_1234, 3 wait states -> resp_rdata=0xFFFF_8001; LHU -> 0x0000_8001.
REQ-038 SHALL cover LW addr 0x8000_0006 -> resp_err=1 one cycle after accept, mem_valid never high; also addr 0x1000_0000 -> same fault.
REQ-039 SHALL cover TIMEOUT=4, mem_ready held 0 -> mem_valid high exactly 4 cycles, then resp_valid with resp_err=1, req_ready=1 next cycle.
REQ-040 SHALL cover reset asserted in BUS with mem_ready=1 same cycle -> next cycle IDLE, resp_valid=0, mem_valid=0.
REQ-041 SHALL cover req_valid held through BUS/RESP -> second request accepted only in next IDLE cycle.

Source files
------------

// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: shared FSM state type, RV32I load/store funct3 codes and the access-fault check
package riscv_lsu_pkg;

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    // funct3[1:0] is 01 for LH/LHU/SH and 10 for LW/SW, so one alignment test covers loads and stores
    function automatic logic access_fault(input logic region_ok, input logic store,
                                          input logic [2:0] f3, input logic [1:0] lo);
        return !region_ok || f3 == 3'd3 || f3[2:1] == 2'b11 || (store && f3 > F3_SW) ||
               (f3[1:0] == 2'b01 && lo[0]) || (f3[1:0] == 2'b10 && lo != 2'b00);
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// lsu_align: byte-lane mask, store data replication and load extraction/extension
//   funct3, store, addr_lo : registered access descriptor
//   wdata / rdata          : raw store data (rs2) / raw bus read word
//   mem_we, mem_wdata      : byte enables and lane-replicated store data
//   load_data              : selected and extended load result
module lsu_align import riscv_lsu_pkg::*; (
    input  logic [2:0]  funct3,
    input  logic        store,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    output logic [31:0] load_data
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rdata[{addr_lo, 3'b000} +: 8];
        h = rdata[{addr_lo[1], 4'b0000} +: 16];
        mem_we = !store ? 4'b0000 :
                 funct3 == F3_SB ? 4'b0001 << addr_lo :
                 funct3 == F3_SH ? 4'b0011 << {addr_lo[1], 1'b0} : 4'b1111;
        mem_wdata = funct3 == F3_SB ? {4{wdata[7:0]}} :
                    funct3 == F3_SH ? {2{wdata[15:0]}} : wdata;
        load_data = funct3 == F3_LB  ? {{24{b[7]}}, b} :
                    funct3 == F3_LBU ? {24'b0, b} :
                    funct3 == F3_LH  ? {{16{h[15]}}, h} :
                    funct3 == F3_LHU ? {16'b0, h} :
                    funct3 == F3_LW  ? rdata : 32'b0;
    end
endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: single-outstanding RV32I load/store unit bridging a core request to a word bus
//   clk, reset (sync, active high)
//   req_*  : core request (valid/ready, store, funct3, addr, wdata)
//   resp_* : one-cycle completion pulse with fault flag and extended load data
//   mem_*  : word-aligned bus with byte enables; held stable until mem_ready
module riscv_lsu import riscv_lsu_pkg::*; #(
    parameter int          AW         = 32,
    parameter logic [3:0]  RAM_REGION = 4'h8,
    parameter int          TIMEOUT    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_store,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic          resp_err,
    output logic [31:0]   resp_rdata,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_we,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);
    localparam int CW = TIMEOUT < 1 ? 1 : $clog2(TIMEOUT + 1);
    // the counter starts at 0 on BUS entry, so TIMEOUT bus cycles have elapsed when it reads TIMEOUT-1
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT < 1 ? 0 : TIMEOUT - 1);

    state_t        state, state_n;
    logic [2:0]    f3_q;
    logic          store_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [CW-1:0] cnt;
    logic          fault;
    logic          timeout;
    logic [3:0]    we;
    logic [31:0]   load_data;

    assign fault    = access_fault(req_addr[AW-1:AW-4] == RAM_REGION, req_store, req_funct3, req_addr[1:0]);
    assign timeout  = TIMEOUT != 0 && cnt == CNT_LAST && !mem_ready;
    assign mem_addr = {addr_q[AW-1:2], 2'b00};
    assign resp_rdata = rdata_q;

    lsu_align u_align (
        .funct3    (f3_q),
        .store     (store_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (mem_rdata),
        .mem_we    (we),
        .mem_wdata (mem_wdata),
        .load_data (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            f3_q    <= '0;
            store_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && req_valid) begin
                f3_q    <= req_funct3;
                store_q <= req_store;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= fault;
                rdata_q <= '0;
                cnt     <= '0;
            end
            if (state == S_BUS) begin
                if (mem_ready)
                    rdata_q <= store_q ? 32'b0 : load_data;
                else if (timeout)
                    err_q <= 1'b1;
                else
                    cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_n    = state;
        req_ready  = 1'b0;
        mem_valid  = 1'b0;
        mem_we     = 4'b0000;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_n = fault ? S_RESP : S_BUS;
            end
            S_BUS: begin
                mem_valid = 1'b1;
                mem_we    = we;
                if (mem_ready || timeout)
                    state_n = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                state_n    = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed scoreboard bench for riscv_lsu with a wait-state memory responder
module tb_riscv_lsu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wait_states = 0;
    int          wcnt = 0;
    int          mv_cycles = 0;
    logic        never_ready = 1'b0;
    logic [31:0] mem_word = 32'd0;
    logic [3:0]  last_we = 4'd0;
    logic [31:0] last_wdata = 32'd0;
    logic [31:0] last_addr = 32'd0;
    logic        prev_v = 1'b0;
    logic [67:0] prev_bus = '0;
    logic        after_resp = 1'b0;

    always #5 clk = ~clk;

    riscv_lsu #(.AW(32), .RAM_REGION(4'h8), .TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // response monitor: pops the scoreboard on every resp_valid; the cycle after a response
    // the unit must be back in IDLE
    always @(negedge clk) begin
        exp_t e;
        if (after_resp) begin
            check("ready_after_resp", req_ready, 1);
            after_resp <= 1'b0;
        end
        if (resp_valid === 1'b1) begin
            after_resp <= 1'b1;
            if (q.size() == 0) begin
                check("unexpected_resp", resp_valid, 0);
            end else begin
                e = q.pop_front();
                check("resp_err", resp_err, e.err);
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_cycle", cyc, e.cyc);
            end
        end
    end

    // memory responder: inserts wait_states stall cycles, records the handshake and
    // requires the bus to stay stable while mem_valid is held
    initial forever begin
        @(negedge clk);
        if (mem_valid === 1'b1) begin
            mv_cycles++;
            if (prev_v)
                check("bus_stable", 32'({mem_addr, mem_we, mem_wdata} !== prev_bus), 0);
            prev_v = 1'b1;
            prev_bus = {mem_addr, mem_we, mem_wdata};
            if (never_ready || wcnt < wait_states) begin
                mem_ready = 1'b0;
                wcnt++;
            end else begin
                mem_ready = 1'b1;
                mem_rdata = mem_word;
                last_we = mem_we;
                last_wdata = mem_wdata;
                last_addr = mem_addr;
            end
        end else begin
            mem_ready = 1'b0;
            wcnt = 0;
            prev_v = 1'b0;
        end
    end

    task automatic wait_done();
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: %0d responses still outstanding", q.size());
            q.delete();
        end
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         input logic e, input logic [31:0] rd, input int lat);
        exp_t x;
        @(negedge clk);
        mv_cycles = 0;
        last_we = 4'd0;
        last_wdata = 32'd0;
        last_addr = 32'd0;
        req_valid = 1'b1;
        req_store = st;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = wd;
        check("req_ready_idle", req_ready, 1);
        x.err = e;
        x.rdata = rd;
        x.cyc = cyc + lat;
        q.push_back(x);
        @(negedge clk);
        req_valid = 1'b0;
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t x;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        reset = 1'b0;

        // stores: read word is all ones so any leak into resp_rdata shows
        mem_word = 32'hFFFF_FFFF;
        wait_states = 0;
        issue(1, 3'd0, 32'h8000_0003, 32'h0000_00A5, 0, 32'h0, 2);
        check("sb_we", last_we, 4'b1000);
        check("sb_wdata", last_wdata, 32'hA5A5_A5A5);
        check("sb_addr", last_addr, 32'h8000_0000);
        check("sb_mv_cycles", mv_cycles, 1);
        issue(1, 3'd1, 32'h8000_0002, 32'h1234_BEEF, 0, 32'h0, 2);
        check("sh_we", last_we, 4'b1100);
        check("sh_wdata", last_wdata, 32'hBEEF_BEEF);
        issue(1, 3'd2, 32'h8000_0008, 32'hDEAD_BEEF, 0, 32'h0, 2);
        check("sw_we", last_we, 4'b1111);
        check("sw_wdata", last_wdata, 32'hDEAD_BEEF);
        check("sw_addr", last_addr, 32'h8000_0008);

        // halfword loads with three wait states
        mem_word = 32'h8001_1234;
        wait_states = 3;
        issue(0, 3'd1, 32'h8000_0002, 32'h0, 0, 32'hFFFF_8001, 5);
        check("lh_mv_cycles", mv_cycles, 4);
        check("lh_we", last_we, 4'b0000);
        issue(0, 3'd5, 32'h8000_0002, 32'h0, 0, 32'h0000_8001, 5);

        // byte / word loads, zero wait
        mem_word = 32'h8034_56F7;
        wait_states = 0;
        issue(0, 3'd0, 32'h8000_0000, 32'h0, 0, 32'hFFFF_FFF7, 2);
        issue(0, 3'd0, 32'h8000_0003, 32'h0, 0, 32'hFFFF_FF80, 2);
        issue(0, 3'd4, 32'h8000_0003, 32'h0, 0, 32'h0000_0080, 2);
        issue(0, 3'd4, 32'h8000_0001, 32'h0, 0, 32'h0000_0056, 2);
        issue(0, 3'd1, 32'h8000_0000, 32'h0, 0, 32'h0000_56F7, 2);
        issue(0, 3'd2, 32'h8000_0004, 32'h0, 0, 32'h8034_56F7, 2);
        check("lw_addr", last_addr, 32'h8000_0004);

        // faults: no bus activity, response one cycle after accept
        issue(0, 3'd2, 32'h8000_0006, 32'h0, 1, 32'h0, 1);
        check("mis_lw_mv", mv_cycles, 0);
        issue(0, 3'd2, 32'h1000_0000, 32'h0, 1, 32'h0, 1);
        check("region_mv", mv_cycles, 0);
        issue(0, 3'd1, 32'h8000_0001, 32'h0, 1, 32'h0, 1);
        issue(0, 3'd3, 32'h8000_0000, 32'h0, 1, 32'h0, 1);
        issue(0, 3'd6, 32'h8000_0000, 32'h0, 1, 32'h0, 1);
        issue(1, 3'd4, 32'h8000_0000, 32'h0, 1, 32'h0, 1);
        check("bad_store_mv", mv_cycles, 0);

        // bus timeout after four cycles
        never_ready = 1'b1;
        issue(0, 3'd2, 32'h8000_0000, 32'h0, 1, 32'h0, 5);
        check("timeout_mv_cycles", mv_cycles, 4);
        never_ready = 1'b0;

        // reset in BUS with mem_ready in the same cycle
        @(negedge clk);
        req_valid = 1'b1;
        req_store = 1'b0;
        req_funct3 = 3'd2;
        req_addr = 32'h8000_0000;
        @(negedge clk);
        req_valid = 1'b0;
        check("pre_reset_mem_valid", mem_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        check("midbus_resp_valid", resp_valid, 0);
        check("midbus_mem_valid", mem_valid, 0);
        check("midbus_req_ready", req_ready, 1);
        check("midbus_mem_we", mem_we, 0);
        reset = 1'b0;
        issue(0, 3'd2, 32'h8000_0004, 32'h0, 0, 32'h8034_56F7, 2);

        // req_valid held: second request only in the next IDLE cycle
        mem_word = 32'h1122_3344;
        @(negedge clk);
        req_valid = 1'b1;
        req_store = 1'b0;
        req_funct3 = 3'd2;
        req_addr = 32'h8000_0000;
        x.err = 1'b0;
        x.rdata = 32'h1122_3344;
        x.cyc = cyc + 2;
        q.push_back(x);
        x.cyc = cyc + 5;
        q.push_back(x);
        check("held_ready0", req_ready, 1);
        @(negedge clk);
        check("held_ready1", req_ready, 0);
        @(negedge clk);
        check("held_ready2", req_ready, 0);
        @(negedge clk);
        check("held_ready3", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        wait_done();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
